// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: ALUXOp codes, FSM state
// encoding, default latencies and small opcode-classification helpers.
// Optional feature macro: MULDIV_MADD_EN (enables the madd opcode).
package muldiv_pkg;

  // ALUXOp encodings presented on xop
  localparam logic [3:0] XOP_MULT  = 4'b0000;
  localparam logic [3:0] XOP_MULTU = 4'b0001;
  localparam logic [3:0] XOP_DIV   = 4'b0010;
  localparam logic [3:0] XOP_DIVU  = 4'b0011;
  localparam logic [3:0] XOP_MTHI  = 4'b0100;
  localparam logic [3:0] XOP_MTLO  = 4'b0101;
  localparam logic [3:0] XOP_MFHI  = 4'b0110;
  localparam logic [3:0] XOP_MFLO  = 4'b0111;
  localparam logic [3:0] XOP_MADD  = 4'b1000;

  // Default busy latencies
  localparam int unsigned DEFAULT_MULT_CYCLES = 5;
  localparam int unsigned DEFAULT_DIV_CYCLES  = 10;

  // Unit sequencing state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // True for opcodes that occupy the unit for several cycles
  function automatic logic is_md_op(input logic [3:0] op);
    case (op)
      XOP_MULT, XOP_MULTU, XOP_DIV, XOP_DIVU: return 1'b1;
`ifdef MULDIV_MADD_EN
      XOP_MADD: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // True for opcodes that take the divide latency
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == XOP_DIV) || (op == XOP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational arithmetic for the multiply/divide unit. Produces the 64-bit
// {hi,lo} value that the selected operation would leave behind.
// Division truncates toward zero, the remainder follows the dividend's sign,
// and divide-by-zero yields {a, 32'hFFFFFFFF}.
// Optional feature macro: MULDIV_MADD_EN (adds the multiply-accumulate path).
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  xop,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic        w_b_zero;

  // Sign-extended operands multiplied at 64 bits give the exact signed product
  // in the low 64 bits; zero extension gives the unsigned product.
  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  assign w_b_zero = (b == 32'd0);

  // Signed division via magnitudes. |0x80000000| is still 0x80000000 when
  // read unsigned, so 0x80000000 / -1 naturally yields quotient 0x80000000
  // and remainder 0 without a special case.
  assign w_a_neg = a[31];
  assign w_b_neg = b[31];
  assign w_a_mag = w_a_neg ? (~a + 32'd1) : a;
  assign w_b_mag = w_b_neg ? (~b + 32'd1) : b;
  assign w_q_mag = w_b_zero ? 32'd0 : (w_a_mag / w_b_mag);
  assign w_r_mag = w_b_zero ? 32'd0 : (w_a_mag % w_b_mag);
  assign w_q_s   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r_s   = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  assign w_q_u = w_b_zero ? 32'd0 : (a / b);
  assign w_r_u = w_b_zero ? 32'd0 : (a % b);

`ifndef MULDIV_MADD_EN
  // HI/LO only feed the accumulate path; keep them visibly consumed.
  logic w_unused_acc;
  assign w_unused_acc = ^{hi, lo};
`endif

  // Select the {hi,lo} outcome for the requested operation
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    result = 64'd0;
    case (xop)
      XOP_MULT:  result = w_prod_s;
      XOP_MULTU: result = w_prod_u;
      XOP_DIV:   result = w_b_zero ? {a, 32'hFFFF_FFFF} : {w_r_s, w_q_s};
      XOP_DIVU:  result = w_b_zero ? {a, 32'hFFFF_FFFF} : {w_r_u, w_q_u};
`ifdef MULDIV_MADD_EN
      XOP_MADD:  result = {hi, lo} + w_prod_s;
`endif
      default:   result = 64'd0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for a scalar pipeline.
// An accepted md operation latches its operands, holds busy for a fixed
// number of cycles and writes {hi,lo} on the edge ending the last busy cycle.
// mthi/mtlo write in one cycle while idle; mfhi/mflo read combinationally.
// Optional feature macro: MULDIV_MADD_EN (xop 1000 becomes multiply-accumulate;
// otherwise it is a no-op that neither starts the unit nor raises stall).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  xop,
  input  logic        mt,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [3:0]       r_xop;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic             w_idle;
  logic             w_accept;
  logic             w_mt_ok;
  logic             w_madd_off;
  logic [63:0]      w_result;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle & start & ~cancel & is_md_op(xop);
  assign w_mt_ok  = w_idle & mt & ~cancel & ~w_accept;

`ifdef MULDIV_MADD_EN
  assign w_madd_off = 1'b0;
`else
  assign w_madd_off = (xop == XOP_MADD);
`endif

  // A disabled madd must not freeze the front end; anything else the decoder
  // strobes holds IF/ID for at least the issue cycle.
  assign stall = r_busy | (start & ~cancel & ~w_madd_off);
  assign busy  = r_busy;
  assign hi    = r_hi;
  assign lo    = r_lo;

  // Arithmetic runs on the operands latched at acceptance and the HI/LO
  // values present at completion.
  muldiv_core u_core (
    .a      (r_a),
    .b      (r_b),
    .xop    (r_xop),
    .hi     (r_hi),
    .lo     (r_lo),
    .result (w_result)
  );

  // Move-from read port: selected register for mfhi/mflo, zero otherwise
  always_comb begin
    mf_out = 32'd0;
    if (xop == XOP_MFHI) begin
      mf_out = r_hi;
    end else if (xop == XOP_MFLO) begin
      mf_out = r_lo;
    end
  end

  // Sequencing FSM: accept/latch, count down busy cycles, commit HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here, operand latches included, is cleared by reset
    // so an interrupted operation leaves nothing behind to commit later.
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_xop   <= XOP_MULT;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_BUSY;
            r_busy  <= 1'b1;
            r_a     <= a;
            r_b     <= b;
            r_xop   <= xop;
            r_cnt   <= is_div_op(xop) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end else if (w_mt_ok) begin
            if (xop == XOP_MTHI) begin
              r_hi <= a;
            end else if (xop == XOP_MTLO) begin
              r_lo <= a;
            end
          end
        end
        ST_BUSY: begin
          // start, mt and cancel are deliberately ignored while busy
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= w_result[63:32];
            r_lo    <= w_result[31:0];
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, meaning busy cycles for mult/multu/madd.
REQ-002 Parameter DIV_CYCLES, default 10, meaning busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  md strobe from the decoder; a mult/multu/div/divu/madd is in EX.
REQ-006 xop  input  4  ALUXOp encoding: 0000 mult, 0001 multu, 0010 div, 0011 divu, 0100 mthi, 0101 mtlo, 0110 mfhi, 0111 mflo, 1000 madd.
REQ-007 mt  input  1  mthi/mtlo strobe.
REQ-008 cancel  input  1  exception/flush in EX; suppresses start and mt in the same cycle.
REQ-009 a  input  32  forwarded rs operand.
REQ-010 b  input  32  forwarded rt operand.
REQ-011 busy  output  1  high while an operation is in flight.
REQ-012 stall  output  1  equals busy | (start & ~cancel); the hazard unit freezes IF/ID on any md/mf/mt while high.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.
REQ-015 mf_out  output  32  hi when xop=0110, lo when xop=0111, else 0; combinational.

Function
REQ-016 States are IDLE and BUSY; the unit SHALL transition IDLE->BUSY on start & ~cancel, and BUSY->IDLE when the counter reaches 1.
REQ-017 On the accepting edge, the unit SHALL latch a, b, and xop, and load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-018 busy SHALL be high for exactly N cycles starting at the cycle after acceptance; HI/LO SHALL update at the edge that ends the last busy cycle.
REQ-019 start or mt while BUSY SHALL be ignored and no state SHALL change; the hazard unit guarantees these never occur.
REQ-020 mult/madd SHALL form a signed 64-bit product; multu SHALL form an unsigned 64-bit product; {hi,lo} SHALL receive the product.
REQ-021 madd SHALL set {hi,lo} = {hi,lo} + signed product, with 64-bit wrap-around and HI/LO sampled at completion.
REQ-022 div SHALL truncate toward zero: lo=quotient, hi=remainder, and the remainder SHALL take the sign of the dividend.
REQ-023 For the div case 0x80000000 / 0xFFFFFFFF, the unit SHALL produce lo=0x80000000 and hi=0.
REQ-024 For division by zero (div or divu), the unit SHALL produce hi=a and lo=0xFFFFFFFF.
REQ-025 mt & ~cancel while IDLE SHALL write a to hi (0100) or lo (0101) at the next edge, with zero latency and busy staying low.
REQ-026 cancel SHALL NOT abort an operation already in BUSY; that operation SHALL complete normally.
REQ-027 xop codes outside the defined set SHALL be treated as no operation.

Reset
REQ-028 While rst_n is low, the unit SHALL immediately force state=IDLE, counter=0, busy=0, hi=0, lo=0, and latched operands=0.
REQ-029 Reset asserted mid-operation SHALL discard the operation, and no HI/LO update SHALL follow release.

Configuration
REQ-030 With MULDIV_MADD_EN defined, xop 1000 SHALL behave per REQ-021.
REQ-031 Without MULDIV_MADD_EN, xop 1000 SHALL be a no-op: no BUSY, and stall SHALL equal busy only.

Structure
REQ-032 A shared package SHALL hold the ALUXOp codes (XOP_MULT through XOP_MADD), the state enum, and the default cycle counts.
REQ-033 Arithmetic SHALL reside in one combinational sub-module, muldiv_core (inputs a, b, xop, hi, lo; output 64-bit result), registered at completion by muldiv_unit.

Verification
REQ-034 mult with a=0xFFFFFFFE (-2), b=3 -> busy for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-035 divu with a=7, b=0 -> busy for 10 cycles, then hi=7 and lo=0xFFFFFFFF; div with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000 and hi=0.
REQ-036 div with a=-7, b=2 -> lo=0xFFFFFFFD and hi=0xFFFFFFFF.
REQ-037 mthi with a=0x12345678, then mfhi next cycle -> mf_out=0x12345678, busy never high; mt with cancel=1 -> hi unchanged.
REQ-038 With MULDIV_MADD_EN, hi=0, lo=0xFFFFFFFF, madd with a=1, b=1 -> hi=1 and lo=0; without the macro, the same stimulus leaves hi/lo unchanged.
REQ-039 rst_n pulsed low at busy cycle 3 of a div -> outputs are 0 immediately, and hi/lo stay 0 after release.
